fetch_queue: RTL and testbench

Parametrised prefetching instruction-fetch unit; successor to the single-entry fetch stage of the five-stage core. Issues in-order read requests to instruction memory with a real request/response handshake, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode with valid/stall semantics. Handles redirect (flush) with squashing of in-flight responses, and raises a misaligned-fetch exception.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared widths and constants for the prefetching fetch unit.
package def_params;
  localparam int ADDR_W_DEF          = 32;
  localparam int INSTR_W_DEF         = 32;
  localparam int EX_W_DEF            = 4;
  localparam int INSTR_STEP          = 4;
  localparam int EX_INSTR_MISALIGNED = 0;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous FIFO; push/pop legality is the caller's responsibility.
// A flush with a concurrent push restarts the FIFO holding just that entry.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, wr_addr;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    wr_addr = wr_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_addr = '0;
      wr_d    = push_i ? bump('0) : '0;
      cnt_d   = push_i ? CNT_W'(1) : '0;
    end else begin
      if (push_i) wr_d = bump(wr_q);
      if (pop_i)  rd_d = bump(rd_q);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by cnt_q, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_addr] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == FULL_C);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch unit: in-order memory requests, a PC tag FIFO
// for in-flight requests, and a queue of fetched instructions presented to decode.
module fetch_queue
  import def_params::*;
#(
  parameter int                ADDR_W          = ADDR_W_DEF,
  parameter int                INSTR_W         = INSTR_W_DEF,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter int                EX_W            = EX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  output logic               mem_rd_enable,
  input  logic               mem_rd_ready,
  input  logic [INSTR_W-1:0] mem_rd_data,
  input  logic               mem_rd_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  PC,
  output logic               pipeline_valid,
  output logic [EX_W-1:0]    exception,
  output logic               exception_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr
);
  localparam int QW     = INSTR_W + ADDR_W + EX_W + 1;
  localparam int QCNT_W = $clog2(DEPTH + 1);
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W  = QCNT_W + 1;
  localparam logic [SUM_W-1:0]  DEPTH_C         = SUM_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C          = ADDR_W'(INSTR_STEP);
  localparam logic [EX_W-1:0]   EX_MISALIGNED_C = EX_W'(EX_INSTR_MISALIGNED);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OCNT_W-1:0] drop_q, drop_d;
  logic              halted_q, halted_d;

  logic              q_push, q_pop, q_full, q_empty;
  logic [QW-1:0]     q_din, q_dout;
  logic [QCNT_W-1:0] q_count;
  logic              tag_full, tag_empty;
  logic [ADDR_W-1:0] tag_pc;
  logic [OCNT_W-1:0] outstanding;
  logic              accept, rsp, misaligned;
  logic [SUM_W-1:0]  in_use;

  // Credit: queued entries plus in-flight requests never exceed the queue size.
  assign in_use        = SUM_W'(q_count) + SUM_W'(outstanding);
  assign mem_rd_enable = reset && !halted_q && !flush && !tag_full && (in_use < DEPTH_C);
  assign mem_rd_addr   = fetch_pc_q;
  assign accept        = mem_rd_enable && mem_rd_ready;
  assign rsp           = mem_rd_valid && !tag_empty;
  assign misaligned    = flush && is_misaligned(flush_addr[1:0]);

  assign q_pop  = !q_empty && !stall && !flush;
  assign q_push = flush ? misaligned : (rsp && (drop_q == '0) && (!q_full || q_pop));
  assign q_din  = flush ? {{INSTR_W{1'b0}}, flush_addr, EX_MISALIGNED_C, 1'b1}
                        : {mem_rd_data, tag_pc, {EX_W{1'b0}}, 1'b0};

  assign pipeline_valid = !q_empty;
  assign {instr, PC, exception, exception_valid} = pipeline_valid ? q_dout : '0;

  fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (q_push),
    .data_i  (q_din),
    .pop_i   (q_pop),
    .flush_i (flush),
    .data_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // Tags survive a flush: stale responses still return and must pop their PC.
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp),
    .flush_i (1'b0),
    .data_o  (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (outstanding)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    halted_d   = halted_q;
    if (flush) begin
      fetch_pc_d = flush_addr;
      drop_d     = outstanding - OCNT_W'(rsp);
      halted_d   = misaligned;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + STEP_C;
      if (rsp && (drop_q != '0)) drop_d = drop_q - OCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  import def_params::*;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_enable;
  logic        mem_rd_ready = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] instr;
  logic [31:0] PC;
  logic        pipeline_valid;
  logic [3:0]  exception;
  logic        exception_valid;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RESET_PC), .EX_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .instr(instr), .PC(PC), .pipeline_valid(pipeline_valid),
    .exception(exception), .exception_valid(exception_valid),
    .stall(stall), .flush(flush), .flush_addr(flush_addr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic en, input logic [31:0] a, input logic v,
      input logic [31:0] ins, input logic [31:0] pc, input logic ev, input logic [3:0] ex);
    return {25'd0, en, a, v, ins, pc, ev, ex};
  endfunction

  function automatic logic [127:0] obs_now();
    return pack(mem_rd_enable, mem_rd_addr, pipeline_valid, instr, PC, exception_valid, exception);
  endfunction

  // Memory contents: every word is a function of its address, never zero.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: in-order responses, each due lat cycles after acceptance.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int lat = 1;
  int cyc = 0;

  // Reference model: plain queues of buffered entries and in-flight PCs.
  typedef struct { logic [31:0] ins; logic [31:0] pc; logic exc; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_out[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_drop = 0;
  bit          m_halt = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_out.delete();
    m_pc   = RESET_PC;
    m_drop = 0;
    m_halt = 1'b0;
  endtask

  function automatic bit model_en(input bit fl);
    return !m_halt && !fl && (m_out.size() < MAXO) && (m_q.size() + m_out.size() < DEPTH);
  endfunction

  function automatic logic [127:0] model_obs(input bit fl);
    ent_t h;
    h.ins = 32'h0; h.pc = 32'h0; h.exc = 1'b0;
    if (m_q.size() > 0) h = m_q[0];
    return pack(model_en(fl), m_pc, m_q.size() > 0, h.ins, h.pc, h.exc, 4'(EX_INSTR_MISALIGNED));
  endfunction

  task automatic model_step(input bit st, input bit rdy, input bit fl, input logic [31:0] fa,
                            input bit rv, input logic [31:0] rd);
    bit          en, pop;
    logic [31:0] rpc;
    ent_t        e;
    en  = model_en(fl);
    pop = (m_q.size() > 0) && !st;
    rpc = 32'h0;
    if (rv && m_out.size() > 0) rpc = m_out.pop_front();
    if (fl) begin
      m_q.delete();
      m_drop = m_out.size();
      m_halt = (fa[1:0] != 2'b00);
      if (m_halt) begin
        e.ins = 32'h0; e.pc = fa; e.exc = 1'b1;
        m_q.push_back(e);
      end
      m_pc = fa;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.ins = rd; e.pc = rpc; e.exc = 1'b0;
          m_q.push_back(e);
        end
      end
      if (en && rdy) begin
        m_out.push_back(m_pc);
        m_pc += 32'd4;
      end
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, then update models.
  // mode 0: no check, 1: check against model, 2: check against texp.
  task automatic cycle(input bit st, input bit rdy, input bit fl, input logic [31:0] fa,
                       input bit rst, input int mode, input string name, input logic [127:0] texp);
    bit          rv;
    logic [31:0] rd;
    mreq_t       r;
    @(negedge clk);
    cyc++;
    reset        = !rst;
    stall        = st;
    mem_rd_ready = rdy;
    flush        = fl;
    flush_addr   = fa;
    rv           = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rd           = rv ? instr_of(mem_q[0].addr) : 32'h0;
    mem_rd_valid = rv;
    mem_rd_data  = rv ? rd : $urandom;
    #1;
    if (rst) begin
      if (mode == 2) check(name, obs_now(), texp);
      model_reset();
      mem_q.delete();
    end else begin
      if (mode == 1) check("model", obs_now(), model_obs(fl));
      if (mode == 2) check(name, obs_now(), texp);
      if (mem_rd_enable && mem_rd_ready) begin
        r.addr = mem_rd_addr;
        r.due  = cyc + lat;
        mem_q.push_back(r);
      end
      if (rv) void'(mem_q.pop_front());
      model_step(st, rdy, fl, fa, rv, rd);
    end
  endtask

  typedef struct {
    bit stall; bit flush; logic [31:0] faddr;
    bit en; logic [31:0] addr; bit v; logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit f, input logic [31:0] fa,
                              input bit en, input logic [31:0] a, input bit v, input logic [31:0] pc);
    vec_t x;
    x.stall = s; x.flush = f; x.faddr = fa; x.en = en; x.addr = a; x.v = v; x.pc = pc;
    return x;
  endfunction

  vec_t vecs[16];

  initial begin
    bit found;
    // Cycle-by-cycle expectations from reset release, 1-cycle memory, ready=1.
    vecs[0]  = mk(0, 0, 32'h0,   1, 32'h00,  0, 32'h00);
    vecs[1]  = mk(0, 0, 32'h0,   1, 32'h04,  0, 32'h00);
    vecs[2]  = mk(0, 0, 32'h0,   1, 32'h08,  1, 32'h00);
    vecs[3]  = mk(1, 0, 32'h0,   1, 32'h0C,  1, 32'h04);
    vecs[4]  = mk(1, 0, 32'h0,   1, 32'h10,  1, 32'h04);
    vecs[5]  = mk(1, 0, 32'h0,   0, 32'h14,  1, 32'h04);
    vecs[6]  = mk(1, 0, 32'h0,   0, 32'h14,  1, 32'h04);
    vecs[7]  = mk(0, 0, 32'h0,   0, 32'h14,  1, 32'h04);
    vecs[8]  = mk(0, 0, 32'h0,   1, 32'h14,  1, 32'h08);
    vecs[9]  = mk(0, 0, 32'h0,   1, 32'h18,  1, 32'h0C);
    vecs[10] = mk(0, 0, 32'h0,   1, 32'h1C,  1, 32'h10);
    vecs[11] = mk(0, 0, 32'h0,   1, 32'h20,  1, 32'h14);
    vecs[12] = mk(0, 1, 32'h100, 0, 32'h24,  1, 32'h18);
    vecs[13] = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h00);
    vecs[14] = mk(0, 0, 32'h0,   1, 32'h104, 0, 32'h00);
    vecs[15] = mk(0, 0, 32'h0,   1, 32'h108, 1, 32'h100);

    lat = 1;
    cycle(0, 1, 0, 32'h0, 1, 0, "", '0);
    cycle(0, 1, 0, 32'h0, 1, 2, "reset_values", pack(0, RESET_PC, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].stall, 1, vecs[i].flush, vecs[i].faddr, 0, 2, $sformatf("vec%0d", i),
            pack(vecs[i].en, vecs[i].addr, vecs[i].v,
                 vecs[i].v ? instr_of(vecs[i].pc) : 32'h0, vecs[i].v ? vecs[i].pc : 32'h0, 0, 0));
    end

    // Long stall: queue fills to DEPTH and requests stop, then drains in order.
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 32'h0, 0, 1, "", '0);
    check("stall_enable_low", {127'd0, mem_rd_enable}, 128'd0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);

    // Memory not ready: address and enable held, nothing skipped.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 32'h0, 0, 1, "", '0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);

    // 3-cycle memory, flush with two requests in flight.
    lat = 3;
    for (int i = 0; i < 10 && m_out.size() < 2; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);
    check("two_outstanding", 128'(m_out.size()), 128'd2);
    cycle(0, 1, 1, 32'h100, 0, 1, "", '0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1, 1, 0, 32'h0, 0, 1, "", '0);
      found = pipeline_valid;
    end
    check("flush_head_arrives", {127'd0, found}, 128'd1);
    check("flush_head_pc", {96'd0, PC}, 128'h100);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);

    // Misaligned redirect: single exception entry, then no requests until next flush.
    cycle(0, 1, 1, 32'h102, 0, 1, "", '0);
    cycle(1, 1, 0, 32'h0, 0, 2, "misaligned_head", pack(0, 32'h102, 1, 32'h0, 32'h102, 1, 4'h0));
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, 32'h0, 0, 1, "", '0);
      check("halted_enable", {127'd0, mem_rd_enable}, 128'd0);
    end
    cycle(0, 1, 1, 32'h200, 0, 1, "", '0);
    cycle(0, 1, 0, 32'h0, 0, 1, "", '0);
    check("resume_request", {95'd0, mem_rd_enable, mem_rd_addr}, {95'd0, 1'b1, 32'h200});
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);

    // Reset mid-stream with two requests in flight.
    for (int i = 0; i < 10 && m_out.size() < 2; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);
    cycle(0, 1, 0, 32'h0, 1, 0, "", '0);
    cycle(0, 1, 0, 32'h0, 0, 2, "reset_midstream", pack(1, RESET_PC, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 32'h0, 0, 1, "", '0);

    // Randomized traffic.
    for (int blk = 0; blk < 8; blk++) begin
      lat = 1 + int'($urandom_range(0, 2));
      for (int i = 0; i < 250; i++) begin
        bit          st, rdy, fl, rs;
        logic [31:0] fa;
        st  = ($urandom_range(0, 9) < 3);
        rdy = ($urandom_range(0, 9) < 7);
        fl  = ($urandom_range(0, 99) < 4);
        rs  = ($urandom_range(0, 499) == 0);
        fa  = 32'h1000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 3) == 0) fa[1:0] = 2'($urandom_range(1, 3));
        cycle(st, rdy, fl, fa, rs, rs ? 0 : 1, "", '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
